// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
//
// Feed stage in front of the adaptive control unit. Incoming opcodes are
// buffered in a small FIFO and issued one opcode/valid pair per cycle. A
// hysteresis governor selects LowPower (0) or HighPerf (1) from the queue
// occupancy. In LowPower the issue rate is throttled to one issue every
// LP_ISSUE_GAP cycles.
//
// Optional feature macro: ISSUE_STATS_EN
//   defined   -> issued_cnt counts issued opcodes (wraps at 2^16, reset only)
//   undefined -> issued_cnt is tied to 0
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   in_opcode      opcode to enqueue
//   in_valid       in_opcode valid
//   in_ready       queue can accept this cycle (!full && !flush, 0 in reset)
//   flush          synchronous queue clear
//   mode_force_en  override the governor
//   mode_force_val forced mode (0=LowPower, 1=HighPerf)
//   opcode         issued opcode (0 when not valid)
//   valid          one-cycle pulse per issued opcode
//   mode           mode select (0=LowPower, 1=HighPerf)
//   occupancy      registered entry count, 0..DEPTH
//   issued_cnt     issue statistics
// -----------------------------------------------------------------------------
module instr_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int OPC_W        = 3,
  parameter int HI_THRESH    = 6,
  parameter int LO_THRESH    = 2,
  parameter int LP_ISSUE_GAP = 4,
  parameter int MIN_DWELL    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OPC_W-1:0]           in_opcode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       mode_force_en,
  input  logic                       mode_force_val,
  output logic [OPC_W-1:0]           opcode,
  output logic                       valid,
  output logic                       mode,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                issued_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int DW    = $clog2(MIN_DWELL + 1);
  localparam int GW    = (LP_ISSUE_GAP > 1) ? $clog2(LP_ISSUE_GAP) : 1;

  typedef enum logic {
    LOWPOWER = 1'b0,
    HIGHPERF = 1'b1
  } mode_e;

  logic [OPC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OCC_W-1:0] occ_q;
  logic [GW-1:0]    gap_q;
  logic [DW-1:0]    dwell_q;
  mode_e            state_q;
  mode_e            state_d;
  logic             full;
  logic             push;
  logic             pop;

  // There is deliberately no push/pop bypass: a full queue refuses input
  // even if the head leaves in the same cycle.
  assign full     = (occ_q == OCC_W'(DEPTH));
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = (occ_q != '0) && (gap_q == '0) && !flush;

  assign occupancy = occ_q;
  assign mode      = state_q;

  // Storage has no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      opcode <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      opcode <= '0;
      valid  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        opcode <= mem[rd_ptr];
        valid  <= 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        opcode <= '0;
        valid  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Issue throttle. Keyed on the next mode so that entering HighPerf
  // clears any pending gap at the same edge; the load uses the current mode
  // because that is the mode the issue happened in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (flush || (state_d == HIGHPERF)) begin
      gap_q <= '0;
    end else if (pop && (state_q == LOWPOWER)) begin
      gap_q <= GW'(LP_ISSUE_GAP - 1);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

  // Governor next-state. Decisions look at registered occupancy only, and a
  // switch is allowed only once the dwell counter has saturated.
  always_comb begin
    state_d = state_q;
    if (mode_force_en) begin
      state_d = mode_e'(mode_force_val);
    end else if (state_q == LOWPOWER) begin
      if ((occ_q >= OCC_W'(HI_THRESH)) && (dwell_q == DW'(MIN_DWELL))) begin
        state_d = HIGHPERF;
      end
    end else begin
      if ((occ_q <= OCC_W'(LO_THRESH)) && (dwell_q == DW'(MIN_DWELL))) begin
        state_d = LOWPOWER;
      end
    end
  end

  // Mode register and dwell counter; flush leaves both untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOWPOWER;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        dwell_q <= '0;
      end else if (dwell_q != DW'(MIN_DWELL)) begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  logic [15:0] issued_q;

  // Counts alongside valid so the value matches the pulses seen so far.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q <= '0;
    end else if (pop) begin
      issued_q <= issued_q + 16'd1;
    end
  end

  assign issued_cnt = issued_q;
`else
  assign issued_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_queue
//
// Directed self-checking bench for instr_issue_queue with default parameters
// (DEPTH=8, gap 4, HI=6, LO=2, dwell 16). Expected values are hand-derived
// cycle by cycle from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_instr_issue_queue;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_opcode;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        mode_force_en;
  logic        mode_force_val;
  logic [2:0]  opcode;
  logic        valid;
  logic        mode;
  logic [3:0]  occupancy;
  logic [15:0] issued_cnt;

  int tests_run;
  int tests_failed;

`ifdef ISSUE_STATS_EN
  localparam logic [15:0] EXP_CNT_AT_FLUSH = 16'd29;
`else
  localparam logic [15:0] EXP_CNT_AT_FLUSH = 16'd0;
`endif

  instr_issue_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_opcode      (in_opcode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .mode_force_en  (mode_force_en),
    .mode_force_val (mode_force_val),
    .opcode         (opcode),
    .valid          (valid),
    .mode           (mode),
    .occupancy      (occupancy),
    .issued_cnt     (issued_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic fl);
    in_valid  = v;
    in_opcode = op;
    flush     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  logic [2:0] got_op [$];
  int         got_t  [$];
  int         w;
  logic       acc;

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    mode_force_en  = 1'b0;
    mode_force_val = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b0);

    // Reset with in_valid held high
    repeat (3) step();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_opcode", opcode, 0);
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_cnt", issued_cnt, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0);
    step();
    checkOutput("rst_no_accept", occupancy, 0);
    checkOutput("rst_no_issue", valid, 0);

    // HighPerf burst: issue every cycle, one cycle after the push edge
    mode_force_en  = 1'b1;
    mode_force_val = 1'b1;
    step();
    checkOutput("hp_mode", mode, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, 3'(i + 1), 1'b0);
      else       applyStimulus(1'b0, 3'd0, 1'b0);
      step();
      checkOutput($sformatf("hp_valid%0d", i), valid, (i >= 1 && i <= 4) ? 1 : 0);
      checkOutput($sformatf("hp_opcode%0d", i), opcode, (i >= 1 && i <= 4) ? i : 0);
    end

    // LowPower throttle: pulses 4 cycles apart
    mode_force_val = 1'b0;
    step();
    checkOutput("lp_mode", mode, 0);
    for (int i = 0; i < 12; i++) begin
      if (i < 3) applyStimulus(1'b1, 3'(5 + i), 1'b0);
      else       applyStimulus(1'b0, 3'd0, 1'b0);
      step();
      checkOutput($sformatf("lp_valid%0d", i), valid,
                  (i == 1 || i == 5 || i == 9) ? 1 : 0);
      checkOutput($sformatf("lp_opcode%0d", i), opcode,
                  (i == 1 || i == 5 || i == 9) ? 5 + (i - 1) / 4 : 0);
    end
    repeat (4) step();

    // Full boundary: 12 words pushed continuously in LowPower
    w = 0;
    applyStimulus(1'b1, 3'd3, 1'b0);
    for (int t = 1; t <= 60; t++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) w++;
      if (w < 12) applyStimulus(1'b1, 3'((w + 3) % 8), 1'b0);
      else        applyStimulus(1'b0, 3'd0, 1'b0);
      if (valid) begin
        got_op.push_back(opcode);
        got_t.push_back(t);
      end
      if (t == 10) begin
        checkOutput("full_occ10", occupancy, 7);
        checkOutput("full_rdy10", in_ready, 1);
      end
      if (t == 11) begin
        checkOutput("full_occ11", occupancy, 8);
        checkOutput("full_rdy11", in_ready, 0);
      end
      if (t == 13) checkOutput("full_rdy13", in_ready, 0);
      if (t == 14) begin
        checkOutput("full_occ14", occupancy, 7);
        checkOutput("full_rdy14", in_ready, 1);
      end
      if (t == 15) checkOutput("full_occ15", occupancy, 8);
    end
    checkOutput("full_accepted", w, 12);
    checkOutput("full_issued", got_op.size(), 12);
    for (int k = 0; k < got_op.size() && k < 12; k++) begin
      checkOutput($sformatf("full_op%0d", k), got_op[k], (k + 3) % 8);
      checkOutput($sformatf("full_t%0d", k), got_t[k], 2 + 4 * k);
    end

    // Governor hysteresis with the force released
    mode_force_en = 1'b0;
    for (int t = 1; t <= 26; t++) begin
      if (t <= 8) applyStimulus(1'b1, 3'(t % 8), 1'b0);
      else        applyStimulus(1'b0, 3'd0, 1'b0);
      step();
      if (t == 8) begin
        checkOutput("gov_mode8", mode, 0);
        checkOutput("gov_occ8", occupancy, 6);
      end
      if (t == 9) begin
        checkOutput("gov_mode9", mode, 1);
        checkOutput("gov_occ9", occupancy, 6);
      end
      if (t == 13) begin
        checkOutput("gov_occ13", occupancy, 2);
        checkOutput("gov_mode13", mode, 1);
      end
      if (t == 25) checkOutput("gov_mode25", mode, 1);
      if (t == 26) checkOutput("gov_mode26", mode, 0);
    end

    // Flush mid-stream at occupancy 5 with a simultaneous push
    for (int t = 1; t <= 7; t++) begin
      applyStimulus(1'b1, 3'(t), 1'b0);
      step();
    end
    checkOutput("fl_pre_occ", occupancy, 5);
    checkOutput("fl_pre_cnt", issued_cnt, EXP_CNT_AT_FLUSH);
    applyStimulus(1'b1, 3'd7, 1'b1);
    #1;
    checkOutput("fl_in_ready", in_ready, 0);
    step();
    checkOutput("fl_occ", occupancy, 0);
    checkOutput("fl_valid", valid, 0);
    checkOutput("fl_opcode", opcode, 0);
    checkOutput("fl_mode", mode, 0);
    checkOutput("fl_cnt", issued_cnt, EXP_CNT_AT_FLUSH);
    applyStimulus(1'b0, 3'd0, 1'b0);
    step();
    checkOutput("fl_dropped", occupancy, 0);
    checkOutput("fl_idle_valid", valid, 0);
    applyStimulus(1'b1, 3'd6, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("fl_repush_occ", occupancy, 1);
    step();
    checkOutput("fl_gap_clear_valid", valid, 1);
    checkOutput("fl_gap_clear_op", opcode, 6);

    // Reset mid-operation discards queued words
    for (int t = 1; t <= 3; t++) begin
      applyStimulus(1'b1, 3'(t + 1), 1'b0);
      step();
    end
    checkOutput("mr_pre_occ", occupancy, 3);
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("mr_in_ready", in_ready, 0);
    step();
    checkOutput("mr_occ", occupancy, 0);
    checkOutput("mr_valid", valid, 0);
    checkOutput("mr_opcode", opcode, 0);
    checkOutput("mr_cnt", issued_cnt, 0);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      checkOutput($sformatf("mr_post_valid%0d", t), valid, 0);
      checkOutput($sformatf("mr_post_occ%0d", t), occupancy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
